// File: rtl/game_state_engine_if.sv
// rtl/game_state_engine_if.sv - player controls in, renderer/score display view out
interface game_state_engine_if #(
   parameter int PW      = 2,
   parameter int SCORE_W = 16,
   parameter int X_W     = 10,
   parameter int CNT_W   = 22
);
   logic               start;
   logic               jump;
   logic               isover;
   logic [PW-1:0]      playernum;
   logic               showhighest;
   logic [1:0]         state;
   logic [X_W-1:0]     dinosaur_Y;
   logic [X_W-1:0]     block_X;
   logic [CNT_W-1:0]   spd;
   logic [SCORE_W-1:0] scr;
   logic               new_record;

   modport master (
      output start, jump, isover, playernum, showhighest,
      input  state, dinosaur_Y, block_X, spd, scr, new_record
   );

   modport slave (
      input  start, jump, isover, playernum, showhighest,
      output state, dinosaur_Y, block_X, spd, scr, new_record
   );
endinterface

// File: rtl/game_state_engine.sv
// rtl/game_state_engine.sv - game FSM, jump/obstacle motion, score, speed ramp and high-score table
module game_state_engine #(
   parameter int NUM_PLAYERS = 4,
   parameter int PW          = 2,
   parameter int SCORE_W     = 16,
   parameter int X_W         = 10,
   parameter int SPAWN_X     = 700,
   parameter int DESPAWN_X   = 50,
   parameter int GROUND_Y    = 450,
   parameter int JUMP_TOP_Y  = 325,
   parameter int CNT_W       = 22,
   parameter int BASE_PERIOD = 500000,
   parameter int PERIOD_STEP = 50000,
   parameter int MIN_PERIOD  = 100000,
   parameter int MAX_LEVEL   = 7
) (
   input logic clk,
   input logic re_start,
   game_state_engine_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, OVER = 2'b10} state_t;
   localparam int LVL_W = $clog2(MAX_LEVEL + 1);

   state_t             st;
   logic [CNT_W-1:0]   counter;
   logic [CNT_W-1:0]   period;
   logic [SCORE_W-1:0] score;
   logic [SCORE_W-1:0] scr;
   logic [SCORE_W-1:0] highest [NUM_PLAYERS];
   logic [LVL_W-1:0]   level;
   logic [X_W-1:0]     dino_y;
   logic [X_W-1:0]     block_x;
   logic               jumping;
   logic               ascending;
   logic               new_record;
   logic               tick;
   logic [PW-1:0]      pn;
   logic [31:0]        dec;

   assign pn = bus.playernum;

   // Compare the total decrement against the headroom so the subtraction never wraps.
   always_comb begin
      dec = 32'(level) * 32'(PERIOD_STEP);
      if (dec >= 32'(BASE_PERIOD - MIN_PERIOD))
         period = CNT_W'(MIN_PERIOD);
      else
         period = CNT_W'(32'(BASE_PERIOD) - dec);
   end

   assign tick = (st == RUN) && !bus.isover && (counter == period - CNT_W'(1));

   always_ff @(posedge clk) begin
      if (re_start) begin
         st         <= IDLE;
         counter    <= '0;
         score      <= '0;
         level      <= '0;
         dino_y     <= X_W'(GROUND_Y);
         block_x    <= X_W'(SPAWN_X);
         jumping    <= 1'b0;
         ascending  <= 1'b1;
         scr        <= '0;
         new_record <= 1'b0;
         for (int i = 0; i < NUM_PLAYERS; i++) highest[i] <= '0;
      end else begin
         new_record <= 1'b0;
         scr        <= bus.showhighest ? highest[pn] : score;
         case (st)
            IDLE, OVER: begin
               if (bus.start) begin
                  st        <= RUN;
                  counter   <= '0;
                  score     <= '0;
                  level     <= '0;
                  dino_y    <= X_W'(GROUND_Y);
                  block_x   <= X_W'(SPAWN_X);
                  jumping   <= 1'b0;
                  ascending <= 1'b1;
               end
            end
            RUN: begin
               if (bus.isover) begin
                  st <= OVER;
                  if (score > highest[pn]) begin
                     highest[pn] <= score;
                     new_record  <= 1'b1;
                  end
               end else begin
                  counter <= tick ? '0 : counter + CNT_W'(1);
                  if (tick) begin
                     if (block_x == X_W'(DESPAWN_X)) begin
                        block_x <= X_W'(SPAWN_X);
                        if (score != {SCORE_W{1'b1}}) score <= score + SCORE_W'(1);
                        if (level != LVL_W'(MAX_LEVEL)) level <= level + LVL_W'(1);
                     end else begin
                        block_x <= block_x - X_W'(1);
                     end
                     if (jumping) begin
                        if (ascending) begin
                           dino_y <= dino_y - X_W'(1);
                           if (dino_y == X_W'(JUMP_TOP_Y + 1)) ascending <= 1'b0;
                        end else begin
                           dino_y <= dino_y + X_W'(1);
                           if (dino_y == X_W'(GROUND_Y - 1)) begin
                              jumping   <= 1'b0;
                              ascending <= 1'b1;
                           end
                        end
                     end
                  end
                  // A request arms the jump only; the first motion waits for the next tick.
                  if (bus.jump && !jumping) begin
                     jumping   <= 1'b1;
                     ascending <= 1'b1;
                  end
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

   assign bus.state      = st;
   assign bus.dinosaur_Y = dino_y;
   assign bus.block_X    = block_x;
   assign bus.spd        = period;
   assign bus.scr        = scr;
   assign bus.new_record = new_record;
endmodule

// File: doc/game_state_engine.md
Name: game_state_engine

Overview:
- Parametrised successor of the single-obstacle dinosaur state register.
- Holds the game FSM (IDLE/RUN/OVER), dinosaur jump motion, obstacle scroll, score, and a per-player high-score table.
- Adds an explicit start handshake, a computed speed ramp per level, saturating arithmetic and a new-record pulse.
- Sits between the input debouncers and the VGA renderer / score display.

Parameters:
- NUM_PLAYERS, 4, entries in the high-score table (power of 2).
- PW, 2, width of playernum, equal to log2(NUM_PLAYERS).
- SCORE_W, 16, width of score and high scores.
- X_W, 10, width of the coordinate outputs.
- SPAWN_X, 700, obstacle start X.
- DESPAWN_X, 50, obstacle X at which it wraps and scores.
- GROUND_Y, 450, dinosaur rest Y.
- JUMP_TOP_Y, 325, jump apex Y (must be less than GROUND_Y).
- CNT_W, 22, width of the tick counter and period.
- BASE_PERIOD, 500000, clocks per motion tick at level 0.
- PERIOD_STEP, 50000, period decrease per level.
- MIN_PERIOD, 100000, period floor (must be at least 2).
- MAX_LEVEL, 7, level saturation value.

Ports:
- clk, in, 1: system clock; single clock domain.
- re_start, in, 1: synchronous active-high reset; clears all state, including the high-score table.
- start, in, 1: level pulse; begins a new game from IDLE or OVER.
- jump, in, 1: jump request.
- isover, in, 1: collision flag from the renderer.
- playernum, in, PW: selects the high-score entry.
- showhighest, in, 1: display selects the high score instead of the current score.
- state, out, 2: 00 IDLE, 01 RUN, 10 OVER.
- dinosaur_Y, out, X_W: dinosaur Y.
- block_X, out, X_W: obstacle X.
- spd, out, CNT_W: current tick period.
- scr, out, SCORE_W: displayed score, registered.
- new_record, out, 1: one-cycle pulse when a high score is written.

Behaviour:
Reset (re_start=1 at a clk edge):
- state=IDLE, dinosaur_Y=GROUND_Y, block_X=SPAWN_X.
- score=0, level=0, counter=0.
- jumping=0, ascending=1.
- all highest[]=0, scr=0, new_record=0.
- spd=BASE_PERIOD.
- re_start overrides every other input.

Period:
- period = max(BASE_PERIOD - level*PERIOD_STEP, MIN_PERIOD), computed without underflow.
- spd=period, combinational from level.

FSM:
- IDLE: start=1 -> RUN next cycle. Entering RUN clears score, level, counter and jump state, and sets block_X=SPAWN_X, dinosaur_Y=GROUND_Y.
- RUN: isover=1 -> OVER next cycle. While in RUN, start is ignored.
- OVER: start=1 -> RUN with the same initialisation as from IDLE. The high-score table is retained.

Tick (RUN only):
- counter increments each cycle.
- When counter==period-1: counter<=0 and a tick occurs, so there is exactly one tick every period cycles.
- In the cycle isover=1 in RUN, there is no tick update and counter holds.

Obstacle (on tick):
- If block_X==DESPAWN_X: block_X<=SPAWN_X, score<=score+1 (saturates at all-ones), level<=level+1 (saturates at MAX_LEVEL).
- Otherwise block_X<=block_X-1.

Jump:
- jump=1 in RUN with jumping=0 sets jumping=1, ascending=1 at the next edge.
- jump while jumping, or outside RUN, is ignored.
- Motion starts at the first tick after jumping is set.
- On tick while ascending: Y<=Y-1; if Y-1==JUMP_TOP_Y then ascending<=0.
- On tick while descending: Y<=Y+1; if Y+1==GROUND_Y then jumping<=0, ascending<=1.
- Full jump = 2*(GROUND_Y-JUMP_TOP_Y) ticks.
- Y is frozen in OVER and IDLE.

High score:
- In the RUN->OVER transition cycle, compare score with highest[playernum].
- If score is strictly greater: write highest[playernum]<=score and pulse new_record for exactly that one cycle.
- playernum is sampled in that cycle only.

Display:
- scr <= showhighest ? highest[playernum] : score, registered with 1-cycle latency in every state.

Simultaneous events:
- re_start beats everything.
- In RUN, isover beats tick and jump.
- Obstacle wrap and jump motion on the same tick both apply.

Test Plan:
Bench parameters: BASE_PERIOD=4, PERIOD_STEP=1, MIN_PERIOD=2, SPAWN_X=20, DESPAWN_X=10, GROUND_Y=30, JUMP_TOP_Y=27, MAX_LEVEL=7.

- Reset and start: re_start then idle 10 cycles -> state=00, block_X=20, dinosaur_Y=30, spd=4, scr=0. Pulse start -> state=01 and block_X decrements by 1 every 4 cycles.
- Wrap and ramp: run 44 cycles after entering RUN -> block_X=20, score=1, spd=3. Continue until level 2 -> spd=2, and spd stays 2 at levels 3..7.
- Jump: pulse jump in RUN -> Y sequence on successive ticks is 29,28,27,28,29,30, then jumping=0. A second jump pulse while Y=28 is ignored.
- Game over and record: score=3, playernum=2, isover=1 -> state=10 next cycle, new_record high for 1 cycle, highest[2]=3. With showhighest=1, scr=3 one cycle later. Start, reach score=2, isover -> no new_record, highest[2] stays 3.
- Collision priority: isover asserted in the same cycle counter==period-1 -> block_X and Y unchanged, state=10.
- Mid-game reset: re_start during a jump at Y=28 with score=5 -> next cycle state=00, Y=30, block_X=20, score=0, and all high scores=0.
